wb_b3_burst_master: RTL

- Wishbone B3 registered-feedback burst master that sits directly upstream of the on-chip RAM slave.
- Converts a single client request into one line-sized wrapping burst: N beats, critical word first.
- Reads return each beat to the client tagged with a line index; writes pull data from the client one word per ack.
- Used by cache-fill and test-loader logic to exercise and feed the RAM's burst path.

---
 rtl/wb_b3_burst_master.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 wrapping-burst master: one client request becomes one
// line-sized burst, critical word first, with err/rty handling.
// Ports: client req_*/busy/done/err, read beat rd_*, write data wr_*,
//        and the Wishbone B3 master bus wbm_*.
// Optional: define WB_B3_BURST_MASTER_TIMEOUT_EN for an 8-bit stb watchdog.
module wb_b3_burst_master #(
  parameter int dw        = 32,
  parameter int aw        = 32,
  parameter int burst_len = 4
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         req_i,
  input  logic                         req_we_i,
  input  logic [aw-1:0]                req_adr_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [dw-1:0]                rd_dat_o,
  output logic                         rd_vld_o,
  output logic [$clog2(burst_len)-1:0] rd_idx_o,
  input  logic [dw-1:0]                wr_dat_i,
  output logic                         wr_pop_o,
  output logic [aw-1:0]                wbm_adr_o,
  output logic [1:0]                   wbm_bte_o,
  output logic [2:0]                   wbm_cti_o,
  output logic                         wbm_cyc_o,
  output logic                         wbm_stb_o,
  output logic                         wbm_we_o,
  output logic [3:0]                   wbm_sel_o,
  output logic [dw-1:0]                wbm_dat_o,
  input  logic                         wbm_ack_i,
  input  logic                         wbm_err_i,
  input  logic                         wbm_rty_i,
  input  logic [dw-1:0]                wbm_dat_i
);

  localparam int L = $clog2(burst_len);
  localparam logic [1:0] BTE =
    (burst_len == 16) ? 2'b11 :
    (burst_len == 8)  ? 2'b10 : 2'b01;
  localparam logic [L-1:0] LAST = L'(burst_len - 1);

  typedef enum logic [2:0] {
    IDLE, BURST, RETRY, DONE, ERR
  } state_t;

  state_t state, state_nx;

  logic             we_q;
  logic [aw-3-L:0]  base;
  logic [L-1:0]     start;
  logic [L-1:0]     beat;
  logic [L-1:0]     idx;
  logic             last;
  logic             in_burst;
  logic             tmo;
  logic             abort;
  logic             beat_ack;
  logic             unused_ok;

  assign unused_ok = &{1'b0, req_adr_i[1:0]};

  assign in_burst = (state == BURST);
  // Index wraps inside the line; never carries into base.
  assign idx      = start + beat;
  assign last     = (beat == LAST);
  assign abort    = in_burst & (wbm_err_i | tmo);
  assign beat_ack = in_burst & wbm_ack_i & ~wbm_err_i
                  & ~wbm_rty_i & ~tmo;

`ifdef WB_B3_BURST_MASTER_TIMEOUT_EN
  logic [7:0] wdt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !in_burst ||
        wbm_ack_i || wbm_err_i || wbm_rty_i)
      wdt <= '0;
    else if (wdt != 8'hff)
      wdt <= wdt + 8'd1;
  end

  assign tmo = in_burst & (wdt == 8'hff);
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (req_i) state_nx = BURST;
      BURST: begin
        if (abort)
          state_nx = ERR;
        else if (wbm_rty_i)
          state_nx = RETRY;
        else if (wbm_ack_i && last)
          state_nx = DONE;
      end
      RETRY: state_nx = BURST;
      DONE:  state_nx = IDLE;
      ERR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      base     <= '0;
      start    <= '0;
      beat     <= '0;
      rd_dat_o <= '0;
      rd_idx_o <= '0;
      rd_vld_o <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_vld_o <= 1'b0;
      if (state == IDLE && req_i) begin
        we_q  <= req_we_i;
        base  <= req_adr_i[aw-1:2+L];
        start <= req_adr_i[2+L-1:2];
        beat  <= '0;
      end
      if (beat_ack) begin
        beat <= beat + 1'b1;
        if (!we_q) begin
          rd_dat_o <= wbm_dat_i;
          rd_idx_o <= idx;
          rd_vld_o <= 1'b1;
        end
      end
    end
  end

  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);
  assign err_o     = (state == ERR);
  assign wbm_cyc_o = in_burst;
  assign wbm_stb_o = in_burst;
  assign wbm_we_o  = in_burst & we_q;
  assign wbm_adr_o = {base, idx, 2'b00};
  assign wbm_bte_o = BTE;
  assign wbm_cti_o = in_burst ? (last ? 3'b111 : 3'b010)
                              : 3'b000;
  assign wbm_sel_o = 4'hf;
  assign wbm_dat_o = wr_dat_i;
  assign wr_pop_o  = wbm_ack_i & wbm_we_o;

endmodule
